piso_serializer: RTL and testbench

//  Parallel-in/serial-out transmit stage that sits directly upstream of the 4-bit SIPO receiver.

---
 rtl/piso_serializer_pkg.sv | 17 +
 rtl/piso_hold_reg.sv | 57 +++++
 rtl/piso_serializer.sv | 116 +++++++++++
 tb/tb_piso_serializer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer.
//   ST_IDLE / ST_SHIFT : state encodings of the serializer FSM
//   DEFAULT_WIDTH      : default word width in bits
//   piso_state_e       : typed FSM state built on the encodings above
package piso_serializer_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } piso_state_e;

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry valid/ready holding buffer in front of the serializer shifter.
//   clk_i    : clock, state updates on posedge
//   rst_ni   : asynchronous active-low reset, empties the buffer
//   data_i   : incoming word
//   valid_i  : data_i is valid
//   ready_o  : buffer empty; a word is accepted on a posedge with valid_i & ready_o
//   take_i   : shifter is loading the buffered word this cycle
//   data_o   : buffered word
//   full_o   : buffer holds a word
module piso_hold_reg #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             take_i,
  output logic [Width-1:0] data_o,
  output logic             full_o
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;
  logic             accept;

  // Ready depends only on registered state, never on valid_i.
  assign ready_o = ~full_q;
  assign accept  = valid_i & ~full_q;

  // take_i only fires while full and accept only while empty, so they never collide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take_i) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmit stage feeding a negedge-sampling SIPO receiver.
// Words arrive over valid/ready into a one-entry holding register and leave LSB-first,
// one bit per clock, with back-to-back words and no gap cycle.
//   clk      : clock, state updates on posedge
//   rst      : asynchronous active-low reset
//   in_data  : parallel word to send
//   in_valid : in_data is valid
//   in_ready : holding register empty
//   s_out    : serial data bit (registered)
//   s_en     : s_out carries a valid bit (registered)
//   s_last   : current bit is bit WIDTH-1 of its word (registered)
//   busy     : shifter active or holding register full
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             s_out,
  output logic             s_en,
  output logic             s_last,
  output logic             busy
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             take;

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bitcnt_q, bitcnt_d;
  logic             s_out_q, s_out_d;
  logic             s_en_q, s_en_d;
  logic             s_last_q, s_last_d;

  piso_hold_reg #(
    .Width (WIDTH)
  ) u_hold (
    .clk_i   (clk),
    .rst_ni  (rst),
    .data_i  (in_data),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .take_i  (take),
    .data_o  (hold_data),
    .full_o  (hold_full)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    take     = 1'b0;
    case (state_q)
      StIdle: begin
        if (hold_full) begin
          shreg_d  = hold_data;
          bitcnt_d = '0;
          take     = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        shreg_d  = shreg_q >> 1;
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == LastCnt) begin
          bitcnt_d = '0;
          if (hold_full) begin
            // Reload on the last bit so the next word follows without a gap.
            shreg_d = hold_data;
            take    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Serial outputs are precomputed from next state so they leave flops directly.
    s_en_d   = (state_d == StShift);
    s_out_d  = s_en_d & shreg_d[0];
    s_last_d = s_en_d & (bitcnt_d == LastCnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      s_out_q  <= 1'b0;
      s_en_q   <= 1'b0;
      s_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      s_out_q  <= s_out_d;
      s_en_q   <= s_en_d;
      s_last_q <= s_last_d;
    end
  end

  assign s_out  = s_out_q;
  assign s_en   = s_en_q;
  assign s_last = s_last_q;
  assign busy   = (state_q == StShift) | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=4 plus a WIDTH=8 instance).
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready, s_out, s_en, s_last, busy;

  logic [7:0] in_data8;
  logic       in_valid8;
  logic       in_ready8, s_out8, s_en8, s_last8, busy8;

  int n_pass;
  int n_total;

  piso_serializer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_out    (s_out),
    .s_en     (s_en),
    .s_last   (s_last),
    .busy     (busy)
  );

  piso_serializer #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data8),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .s_out    (s_out8),
    .s_en     (s_en8),
    .s_last   (s_last8),
    .busy     (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit SIPO: s_in enters at the MSB, shifts right on negedge when s_en.
  logic [3:0] sipo_q;
  logic [1:0] sipo_cnt;
  logic [3:0] sipo_words[$];

  always @(negedge clk) begin
    if (!rst) begin
      sipo_cnt <= 2'd0;
    end else if (s_en) begin
      sipo_q <= {s_out, sipo_q[3:1]};
      if (sipo_cnt == 2'd3) sipo_words.push_back({s_out, sipo_q[3:1]});
      sipo_cnt <= sipo_cnt + 2'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // word, and its serial stream written in transmission order (first bit at the left).
  typedef struct {
    logic [3:0] word;
    logic [3:0] stream;
  } vec_t;

  vec_t vecs[6];

  // Send one word into an idle DUT and check a 6-cycle window after the accept edge.
  task automatic send_check(input vec_t v);
    logic [5:0] en_pat, busy_pat;
    logic [3:0] stream, last_pat;
    en_pat = '0; busy_pat = '0; stream = '0; last_pat = '0;
    sipo_words.delete();
    @(negedge clk);
    check($sformatf("ready before %h", v.word), 32'(in_ready), 32'(1'b1));
    in_data  = v.word;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      en_pat   = {en_pat[4:0], s_en};
      busy_pat = {busy_pat[4:0], busy};
      if (s_en) begin
        stream   = {stream[2:0], s_out};
        last_pat = {last_pat[2:0], s_last};
      end
    end
    check($sformatf("s_en window %h", v.word), 32'(en_pat), 32'(6'b011110));
    check($sformatf("busy window %h", v.word), 32'(busy_pat), 32'(6'b111110));
    check($sformatf("stream %h", v.word), 32'(stream), 32'(v.stream));
    check($sformatf("s_last %h", v.word), 32'(last_pat), 32'(4'b0001));
    check($sformatf("sipo %h", v.word),
          32'((sipo_words.size() == 1) ? sipo_words[0] : 4'bxxxx), 32'(v.word));
  endtask

  // Stream n random words through the DUT; queue model of accepted vs delivered words.
  task automatic run_stream(input int n, input bit gappy, input string tag);
    logic [3:0] src[$], orig[$], acc[$], rx[$];
    logic [3:0] cur, w;
    logic [1:0] bitn;
    int cyc, bp, n_en, first, lastc, last_err, bad_rx, bad_sipo;
    bit drop;
    cur = '0; bitn = 2'd0; cyc = 0; bp = 0; n_en = 0; first = -1; lastc = -1;
    last_err = 0; bad_rx = 0; bad_sipo = 0; drop = 1'b0;
    sipo_words.delete();
    for (int i = 0; i < n; i++) begin
      w = 4'($urandom_range(0, 15));
      src.push_back(w);
      orig.push_back(w);
    end
    while (rx.size() < n && cyc < 16 * n + 40) begin
      @(negedge clk);
      cyc++;
      if (s_en) begin
        cur[bitn] = s_out;
        if (s_last !== (bitn == 2'd3)) last_err++;
        n_en++;
        if (first < 0) first = cyc;
        lastc = cyc;
        if (bitn == 2'd3) rx.push_back(cur);
        bitn = bitn + 2'd1;
      end
      if (drop) begin
        in_valid = 1'b0;
        drop = 1'b0;
      end
      if (!in_valid && src.size() > 0 && !(gappy && $urandom_range(0, 2) == 0)) begin
        in_data  = src.pop_front();
        in_valid = 1'b1;
      end
      if (in_valid && in_ready) begin
        acc.push_back(in_data);
        drop = 1'b1;
      end else if (in_valid) begin
        bp++;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i >= rx.size() || rx[i] !== orig[i]) bad_rx++;
      if (i >= sipo_words.size() || sipo_words[i] !== orig[i]) bad_sipo++;
    end
    check({tag, " accepted"}, 32'(acc.size()), 32'(n));
    check({tag, " delivered"}, 32'(rx.size()), 32'(n));
    check({tag, " order"}, 32'(bad_rx), 32'(0));
    check({tag, " sipo"}, 32'(bad_sipo), 32'(0));
    check({tag, " s_last"}, 32'(last_err), 32'(0));
    check({tag, " s_en cycles"}, 32'(n_en), 32'(4 * n));
    if (!gappy) begin
      check({tag, " contiguous"}, 32'(lastc - first + 1), 32'(4 * n));
      check({tag, " backpressure"}, 32'(bp > 0), 32'(1));
    end
  endtask

  initial begin
    logic [15:0] en16;
    logic [7:0]  stream8, last8;
    int          n_en, first, lastc, idle_act;
    bit          drop;

    n_pass = 0; n_total = 0;
    rst = 1'b0;
    in_data = 4'h0; in_valid = 1'b0;
    in_data8 = 8'h00; in_valid8 = 1'b0;

    vecs[0] = '{word: 4'b1011, stream: 4'b1101};
    vecs[1] = '{word: 4'hA,    stream: 4'b0101};
    vecs[2] = '{word: 4'h5,    stream: 4'b1010};
    vecs[3] = '{word: 4'h6,    stream: 4'b0110};
    vecs[4] = '{word: 4'h0,    stream: 4'b0000};
    vecs[5] = '{word: 4'h8,    stream: 4'b0001};

    // Reset held with in_valid high: nothing may be accepted.
    in_data  = 4'hC;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("reset outputs %0d", k), 32'({in_ready, s_en, s_out, s_last, busy}),
            32'(5'b10000));
    end
    in_valid = 1'b0;
    rst = 1'b1;
    idle_act = 0;
    repeat (3) begin
      @(negedge clk);
      idle_act += int'(s_en | busy);
    end
    check("nothing accepted in reset", 32'(idle_act), 32'(0));

    // Single words from the table.
    for (int i = 0; i < 6; i++) send_check(vecs[i]);

    // Back-to-back 4'hA then 4'h5 with in_valid held.
    sipo_words.delete();
    en16 = '0; stream8 = '0; n_en = 0; first = -1; lastc = -1; drop = 1'b0;
    @(negedge clk);
    in_data = 4'hA; in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 4'h5;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      en16 = {en16[14:0], s_en};
      if (s_en) begin
        stream8 = {stream8[6:0], s_out};
        n_en++;
        if (first < 0) first = k;
        lastc = k;
      end
      if (drop) begin
        in_valid = 1'b0;
        drop = 1'b0;
      end
      if (in_valid && in_ready) drop = 1'b1;
    end
    in_valid = 1'b0;
    check("b2b s_en count", 32'(n_en), 32'(8));
    check("b2b contiguous", 32'(lastc - first + 1), 32'(8));
    check("b2b stream", 32'(stream8), 32'(8'b01011010));
    check("b2b sipo count", 32'(sipo_words.size()), 32'(2));
    check("b2b sipo first", 32'((sipo_words.size() > 0) ? sipo_words[0] : 4'bxxxx), 32'(4'hA));
    check("b2b sipo second", 32'((sipo_words.size() > 1) ? sipo_words[1] : 4'bxxxx), 32'(4'h5));

    // Back-pressure: three words offered continuously, then randomized traffic.
    run_stream(3, 1'b0, "bp3");
    run_stream(20, 1'b0, "rand_cont");
    run_stream(30, 1'b1, "rand_gappy");

    // Reset after two bits of 4'hF with 4'h9 buffered behind it.
    @(negedge clk);
    in_data = 4'hF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("F bit0 en", 32'({s_en, s_out}), 32'(2'b11));
    in_data = 4'h9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("F bit1 en, 9 buffered", 32'({s_en, s_out, in_ready}), 32'(3'b110));
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async reset drop", 32'({s_en, s_out, s_last, busy, in_ready}), 32'(5'b00001));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_act = 0;
    repeat (8) begin
      @(negedge clk);
      idle_act += int'(s_en | busy);
    end
    check("nothing resumes after reset", 32'(idle_act), 32'(0));
    send_check(vecs[3]);

    // WIDTH=8 instance: 8'hC3.
    stream8 = '0; last8 = '0; n_en = 0; first = -1; lastc = -1;
    @(negedge clk);
    check("w8 ready", 32'(in_ready8), 32'(1'b1));
    in_data8 = 8'hC3; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (s_en8) begin
        stream8 = {stream8[6:0], s_out8};
        last8   = {last8[6:0], s_last8};
        n_en++;
        if (first < 0) first = k;
        lastc = k;
      end
    end
    check("w8 s_en count", 32'(n_en), 32'(8));
    check("w8 contiguous", 32'(lastc - first + 1), 32'(8));
    check("w8 stream", 32'(stream8), 32'(8'b11000011));
    check("w8 s_last", 32'(last8), 32'(8'b00000001));
    check("w8 idle after", 32'({busy8, s_en8}), 32'(2'b00));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
